// File: rtl/cordic_result_writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : cordic_result_writeback_arbiter_pkg
// Brief  : Core indices, per-core word counts and tag tables for result writeback.
// Rev    : 1.0  initial release
// ============================================================================
package cordic_result_writeback_arbiter_pkg;

  localparam int NUM_CORES = 8;
  localparam int DATA_W    = 32;
  localparam int MAX_WORDS = 3;
  localparam int TAG_W     = 16;
  localparam int CORE_W    = 3;
  localparam int CNT_W     = 2;

  localparam logic [CORE_W-1:0] CORE_SINCOS = 3'd0;
  localparam logic [CORE_W-1:0] CORE_SINH   = 3'd1;
  localparam logic [CORE_W-1:0] CORE_TANH   = 3'd2;
  localparam logic [CORE_W-1:0] CORE_ARCSIN = 3'd3;
  localparam logic [CORE_W-1:0] CORE_EXP    = 3'd4;
  localparam logic [CORE_W-1:0] CORE_LN     = 3'd5;
  localparam logic [CORE_W-1:0] CORE_SQRT   = 3'd6;
  localparam logic [CORE_W-1:0] CORE_ARCTAN = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } wb_state_t;

  function automatic logic [CNT_W-1:0] nwords(input logic [CORE_W-1:0] core);
    case (core)
      CORE_SINCOS, CORE_SINH, CORE_ARCSIN: nwords = 2'd2;
      CORE_TANH:                           nwords = 2'd3;
      default:                             nwords = 2'd1;
    endcase
  endfunction

  function automatic logic [TAG_W-1:0] word_tag(input logic [CORE_W-1:0] core,
                                                input logic [CNT_W-1:0]  word);
    case (core)
      CORE_EXP:    word_tag = 16'h000e;
      CORE_LN:     word_tag = 16'h000f;
      CORE_SQRT:   word_tag = 16'h000d;
      CORE_ARCTAN: word_tag = 16'h000b;
      CORE_TANH:   word_tag = (word == 2'd2) ? 16'h000b :
                              (word == 2'd1) ? 16'h000c : 16'h000a;
      default:     word_tag = (word == 2'd1) ? 16'h000c : 16'h000a;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_result_writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : cordic_result_writeback_arbiter_if
// Brief  : Core-side done/result bus and FIFO-side write port of the arbiter.
// Rev    : 1.0  initial release
// ============================================================================
interface cordic_result_writeback_arbiter_if;
  import cordic_result_writeback_arbiter_pkg::*;

  logic [NUM_CORES-1:0]                  core_done;
  logic [NUM_CORES*MAX_WORDS*DATA_W-1:0] core_res;
  logic                                  wr_full;
  logic                                  wr_en;
  logic [TAG_W+DATA_W-1:0]               wr_data;
  logic [NUM_CORES-1:0]                  slot_busy;
  logic                                  overflow;

  modport master (
    input  core_done, core_res, wr_full,
    output wr_en, wr_data, slot_busy, overflow
  );

  modport slave (
    output core_done, core_res, wr_full,
    input  wr_en, wr_data, slot_busy, overflow
  );

endinterface
`default_nettype wire

// File: rtl/cordic_result_writeback_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : cordic_rr_pick
// Brief  : First valid index at or after rr_ptr, wrapping; purely combinational.
// Rev    : 1.0  initial release
// ============================================================================
module cordic_rr_pick #(
  parameter int NUM_CORES = 8,
  parameter int CORE_W    = 3
) (
  input  logic [NUM_CORES-1:0] valid,
  input  logic [CORE_W-1:0]    rr_ptr,
  output logic [CORE_W-1:0]    grant,
  output logic                 any_valid
);

  logic [CORE_W-1:0] w_idx;

  // Scan farthest-first so the closest valid index to rr_ptr is written last.
  always_comb begin
    grant = '0;
    w_idx = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      w_idx = CORE_W'((int'(rr_ptr) + k) % NUM_CORES);
      if (valid[w_idx]) grant = w_idx;
    end
    any_valid = |valid;
  end

endmodule
`default_nettype wire

// File: rtl/cordic_result_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module : cordic_result_writeback_arbiter
// Brief  : Per-core result slots drained round-robin onto one tagged FIFO port.
// Rev    : 1.0  initial release
// ============================================================================
module cordic_result_writeback_arbiter
  import cordic_result_writeback_arbiter_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset,
  cordic_result_writeback_arbiter_if.master bus
);

  localparam int SLOT_W = MAX_WORDS * DATA_W;

  logic [NUM_CORES-1:0] r_valid;
  logic [SLOT_W-1:0]    r_slot [NUM_CORES];
  wb_state_t            r_state, w_state_nxt;
  logic [CORE_W-1:0]    r_grant, r_rr_ptr, w_pick;
  logic [CNT_W-1:0]     r_word_cnt;
  logic                 r_overflow;
  logic                 w_any, w_wr_en, w_last;
  logic [NUM_CORES-1:0] w_release, w_drop;
  logic [SLOT_W-1:0]    w_sel;

  cordic_rr_pick #(
    .NUM_CORES (NUM_CORES),
    .CORE_W    (CORE_W)
  ) u_pick (
    .valid     (r_valid),
    .rr_ptr    (r_rr_ptr),
    .grant     (w_pick),
    .any_valid (w_any)
  );

  // A done on the release cycle of its own slot reloads instead of overflowing.
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot_ctl
    assign w_release[i] = w_last && (r_grant == CORE_W'(i));
    assign w_drop[i]    = bus.core_done[i] && r_valid[i] && !w_release[i];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: if (w_any) w_state_nxt = ST_SEND;
      ST_SEND: begin
        w_wr_en = !bus.wr_full;
        if (w_wr_en && (r_word_cnt == nwords(r_grant) - 2'd1)) begin
          w_last      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_word_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_any) begin
          r_grant    <= w_pick;
          r_word_cnt <= '0;
        end
        ST_SEND: begin
          if (w_last) begin
            r_word_cnt <= '0;
            r_rr_ptr   <= (r_grant == CORE_W'(NUM_CORES - 1)) ? '0 : r_grant + 1'b1;
          end else if (w_wr_en) begin
            r_word_cnt <= r_word_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= '0;
      r_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (bus.core_done[i] && (!r_valid[i] || w_release[i])) r_valid[i] <= 1'b1;
        else if (w_release[i])                                  r_valid[i] <= 1'b0;
      end
      r_overflow <= r_overflow | (|w_drop);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (bus.core_done[i] && (!r_valid[i] || w_release[i]))
        r_slot[i] <= bus.core_res[i*SLOT_W +: SLOT_W];
    end
  end

  assign w_sel         = r_slot[r_grant];
  assign bus.wr_en     = w_wr_en;
  assign bus.wr_data   = {word_tag(r_grant, r_word_cnt), w_sel[32'(r_word_cnt)*DATA_W +: DATA_W]};
  assign bus.slot_busy = r_valid;
  assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cordic_result_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_cordic_result_writeback_arbiter
// Brief  : Directed, table-driven bench for the result writeback arbiter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cordic_result_writeback_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_result_writeback_arbiter_if bus ();

  cordic_result_writeback_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          edge_no;
    logic [47:0] data;
  } wr_t;
  wr_t log_q[$];

  typedef struct {
    int          core;
    logic [31:0] w[3];
    int          n;
    logic [47:0] exp[4];
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Writes are logged with the clock edge that commits them into the FIFO.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) log_q.push_back('{cyc + 1, bus.wr_data});
    if (bus.wr_full) check("no_write_while_full", 64'(bus.wr_en), 64'd0);
  end

  task automatic set_words(input int core, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c);
    bus.core_res[(core*3+0)*32 +: 32] = a;
    bus.core_res[(core*3+1)*32 +: 32] = b;
    bus.core_res[(core*3+2)*32 +: 32] = c;
  endtask

  task automatic fire(input logic [7:0] mask, output int cap);
    bus.core_done = mask;
    @(posedge clk); #1;
    bus.core_done = '0;
    cap = cyc;
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk); #1;
      if (bus.slot_busy == 8'h00 && bus.wr_en == 1'b0) ok = 1'b1;
    end
    check({name, "_drain"}, 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic expect_writes(input string name, input int n, input logic [47:0] d[4],
                               input int e[4]);
    check({name, "_count"}, 64'(log_q.size()), 64'(n));
    for (int j = 0; j < n && j < log_q.size(); j++) begin
      check($sformatf("%s_data%0d", name, j), 64'(log_q[j].data), 64'(d[j]));
      check($sformatf("%s_edge%0d", name, j), 64'(log_q[j].edge_no), 64'(e[j]));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int cap, cap2, n0;

    vecs[0] = '{core:4, w:'{32'h3F800000, 32'h0, 32'h0}, n:1,
                exp:'{48'h000e_3F800000, 48'h0, 48'h0, 48'h0}};
    vecs[1] = '{core:2, w:'{32'h11111111, 32'h22222222, 32'h33333333}, n:3,
                exp:'{48'h000a_11111111, 48'h000c_22222222, 48'h000b_33333333, 48'h0}};
    vecs[2] = '{core:0, w:'{32'hA0A0A0A0, 32'hB0B0B0B0, 32'h0}, n:2,
                exp:'{48'h000a_A0A0A0A0, 48'h000c_B0B0B0B0, 48'h0, 48'h0}};
    vecs[3] = '{core:1, w:'{32'h01234567, 32'h89ABCDEF, 32'h0}, n:2,
                exp:'{48'h000a_01234567, 48'h000c_89ABCDEF, 48'h0, 48'h0}};
    vecs[4] = '{core:3, w:'{32'hDEADBEEF, 32'hCAFEF00D, 32'h0}, n:2,
                exp:'{48'h000a_DEADBEEF, 48'h000c_CAFEF00D, 48'h0, 48'h0}};
    vecs[5] = '{core:6, w:'{32'h00010000, 32'h0, 32'h0}, n:1,
                exp:'{48'h000d_00010000, 48'h0, 48'h0, 48'h0}};
    vecs[6] = '{core:7, w:'{32'hFFFFFFFF, 32'h0, 32'h0}, n:1,
                exp:'{48'h000b_FFFFFFFF, 48'h0, 48'h0, 48'h0}};
    vecs[7] = '{core:5, w:'{32'h7FFFFFFF, 32'h55555555, 32'h0}, n:1,
                exp:'{48'h000f_7FFFFFFF, 48'h0, 48'h0, 48'h0}};

    reset         = 1'b1;
    bus.core_done = '0;
    bus.core_res  = '0;
    bus.wr_full   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en",     64'(bus.wr_en),          64'd0);
    check("rst_slot_busy", 64'(bus.slot_busy),      64'd0);
    check("rst_overflow",  64'(bus.overflow),       64'd0);
    check("rst_state",     64'(dut.r_state),        64'd0);
    check("rst_rr_ptr",    64'(dut.r_rr_ptr),       64'd0);
    check("rst_word_cnt",  64'(dut.r_word_cnt),     64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single-job vectors; the last one leaves rr_ptr at 6 for the round-robin case.
    for (int v = 0; v < 8; v++) begin
      log_q.delete();
      set_words(vecs[v].core, vecs[v].w[0], vecs[v].w[1], vecs[v].w[2]);
      fire(8'(1 << vecs[v].core), cap);
      check($sformatf("vec%0d_busy_set", v), 64'(bus.slot_busy[vecs[v].core]), 64'd1);
      drain($sformatf("vec%0d", v));
      expect_writes($sformatf("vec%0d", v), vecs[v].n, vecs[v].exp,
                    '{cap + 2, cap + 3, cap + 4, 0});
      check($sformatf("vec%0d_busy_clr", v), 64'(bus.slot_busy), 64'd0);
      check($sformatf("vec%0d_overflow", v), 64'(bus.overflow), 64'd0);
    end

    // Simultaneous dones on 0,5,7 with rr_ptr=6: order 7,0,5.
    check("rr_ptr_before", 64'(dut.r_rr_ptr), 64'd6);
    log_q.delete();
    set_words(0, 32'hC0C0C0C0, 32'hC1C1C1C1, 32'h0);
    set_words(5, 32'h50505050, 32'h0, 32'h0);
    set_words(7, 32'h70707070, 32'h0, 32'h0);
    fire(8'b1010_0001, cap);
    check("rr_busy_set", 64'(bus.slot_busy), 64'hA1);
    drain("rr");
    expect_writes("rr", 4, '{48'h000b_70707070, 48'h000a_C0C0C0C0,
                             48'h000c_C1C1C1C1, 48'h000f_50505050},
                  '{cap + 2, cap + 4, cap + 5, cap + 7});
    check("rr_ptr_after", 64'(dut.r_rr_ptr), 64'd6);

    // Back-pressure: full for 5 cycles after word0 of a core0 job.
    log_q.delete();
    set_words(0, 32'h44440000, 32'h44440001, 32'h0);
    fire(8'h01, cap);
    @(posedge clk);
    @(posedge clk); #1;
    bus.wr_full = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("stall_word_cnt", 64'(dut.r_word_cnt), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    bus.wr_full = 1'b0;
    drain("stall");
    expect_writes("stall", 2, '{48'h000a_44440000, 48'h000c_44440001, 48'h0, 48'h0},
                  '{cap + 2, cap + 8, 0, 0});

    // Second done while pending: dropped, overflow sticks.
    log_q.delete();
    set_words(1, 32'h11110001, 32'h11110002, 32'h0);
    fire(8'h02, cap);
    set_words(1, 32'h22220001, 32'h22220002, 32'h0);
    fire(8'h02, cap2);
    drain("ovf");
    check("ovf_set", 64'(bus.overflow), 64'd1);
    expect_writes("ovf", 2, '{48'h000a_11110001, 48'h000c_11110002, 48'h0, 48'h0},
                  '{cap + 2, cap + 3, 0, 0});
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("ovf_cleared", 64'(bus.overflow), 64'd0);

    // Done on the last-word cycle reloads the slot without overflow.
    log_q.delete();
    set_words(1, 32'h33330001, 32'h33330002, 32'h0);
    fire(8'h02, cap);
    @(posedge clk);
    @(posedge clk); #1;
    set_words(1, 32'h44440001, 32'h44440002, 32'h0);
    fire(8'h02, cap2);
    check("reload_cap_edge", 64'(cap2), 64'(cap + 3));
    drain("reload");
    check("reload_overflow", 64'(bus.overflow), 64'd0);
    expect_writes("reload", 4, '{48'h000a_33330001, 48'h000c_33330002,
                                 48'h000a_44440001, 48'h000c_44440002},
                  '{cap + 2, cap + 3, cap + 5, cap + 6});

    // Reset during word1 of a tanh job (with overflow pending) drops everything.
    log_q.delete();
    set_words(2, 32'h66660000, 32'h66660001, 32'h66660002);
    fire(8'h04, cap);
    fire(8'h04, cap2);
    @(posedge clk); #1;
    check("rst_mid_ovf_pre", 64'(bus.overflow), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n0 = log_q.size();
    check("rst_mid_words_before", 64'(n0), 64'd2);
    check("rst_mid_wr_en",     64'(bus.wr_en),      64'd0);
    check("rst_mid_slot_busy", 64'(bus.slot_busy),  64'd0);
    check("rst_mid_overflow",  64'(bus.overflow),   64'd0);
    check("rst_mid_state",     64'(dut.r_state),    64'd0);
    check("rst_mid_rr_ptr",    64'(dut.r_rr_ptr),   64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("rst_mid_no_more_writes", 64'(log_q.size()), 64'(n0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
